// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int BYTE_LANES = 4;
    localparam int LAT_CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous byte-enabled write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [BYTE_LANES-1:0] be_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: valid/ready request, fixed access latency,
// byte-enabled stores, range check and pipeline stall generation.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [BYTE_LANES-1:0] req_be,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  stall
);

    localparam logic [LAT_CNT_W-1:0] LAT_M1 = LAT_CNT_W'(LATENCY - 1);
    localparam bit                   SINGLE = (LATENCY == 1);

    dmem_state_e           state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  oor_q, oor_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [BYTE_LANES-1:0] be_q, be_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept_s;
    logic                  req_oor_s;
    logic                  acc_wr_s;
    logic [ADDR_W-1:0]     acc_addr_s;
    logic                  acc_oor_s;
    logic [31:0]           acc_wdata_s;
    logic [BYTE_LANES-1:0] acc_be_s;
    logic                  access_s;
    logic                  we_s;
    logic [31:0]           mem_rdata_s;
    logic                  unused_addr_s;

    assign req_ready     = (state_q == ST_IDLE) & ~rst;
    assign accept_s      = req_valid & req_ready;
    assign req_oor_s     = |req_addr[31:ADDR_W+2];
    assign unused_addr_s = ^req_addr[1:0];

    // With LATENCY==1 the access is performed on the accept edge, so it must use the live request.
    assign acc_wr_s    = (state_q == ST_IDLE) ? req_wr                : wr_q;
    assign acc_addr_s  = (state_q == ST_IDLE) ? req_addr[ADDR_W+1:2] : addr_q;
    assign acc_oor_s   = (state_q == ST_IDLE) ? req_oor_s             : oor_q;
    assign acc_wdata_s = (state_q == ST_IDLE) ? req_wdata             : wdata_q;
    assign acc_be_s    = (state_q == ST_IDLE) ? req_be                : be_q;

    assign access_s = (state_q == ST_IDLE) ? (accept_s & SINGLE)
                                           : ((state_q == ST_WAIT) && (cnt_q <= LAT_CNT_W'(1)));
    assign we_s     = access_s & acc_wr_s & ~acc_oor_s & ~rst;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we_i    (we_s),
        .addr_i  (acc_addr_s),
        .wdata_i (acc_wdata_s),
        .be_i    (acc_be_s),
        .rdata_o (mem_rdata_s)
    );

    // Next-state, counter, request latch and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        oor_d        = oor_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr[ADDR_W+1:2];
                    oor_d   = req_oor_s;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = LAT_M1;
                    state_d = SINGLE ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != LAT_CNT_W'(0)) begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (access_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
        if (access_s) begin
            resp_valid_d = 1'b1;
            rdata_d      = (acc_wr_s | acc_oor_s) ? 32'd0 : mem_rdata_s;
            err_d        = acc_oor_s;
        end else begin
            rdata_d = rdata_d;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= LAT_CNT_W'(0);
            wr_q         <= 1'b0;
            addr_q       <= '0;
            oor_q        <= 1'b0;
            wdata_q      <= 32'd0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            oor_q        <= oor_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign stall      = req_valid & ~resp_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) share one request bus.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [2:0]  ready, rvalid, err, stall;
    logic [31:0] rdata [3];

    int checks   = 0;
    int failures = 0;
    logic [31:0] mdl [1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_wr     (req_wr),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_be     (req_be),
            .req_ready  (ready[g]),
            .resp_valid (rvalid[g]),
            .resp_rdata (rdata[g]),
            .resp_err   (err[g]),
            .stall      (stall[g])
        );
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One access on the LATENCY=2 instance, checking handshake timing and stall.
    task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input bit scramble,
                              output logic [31:0] rd, output logic er);
        int c;
        int stall_cnt;
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        #1;
        chk("ready_idle", 32'(ready[0]), 32'd1);
        chk("stall_req", 32'(stall[0]), 32'd1);
        stall_cnt = 1;
        @(posedge clk);
        #1;
        if (scramble) begin
            req_wr = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
        end
        c = 0; got = 0;
        while (c < 40 && !got) begin
            @(negedge clk);
            c++;
            if (rvalid[0]) begin
                got = 1;
            end else begin
                chk("stall_wait", 32'(stall[0]), 32'(req_valid));
                if (stall[0]) stall_cnt++;
            end
        end
        chk("latency", 32'(c), 32'd2);
        chk("stall_resp", 32'(stall[0]), 32'd0);
        if (!scramble) chk("stall_cycles", 32'(stall_cnt), 32'd2);
        rd = rdata[0]; er = err[0];
        req_valid = 1'b0;
        @(negedge clk);
        chk("resp_pulse_end", 32'(rvalid[0]), 32'd0);
        chk("rdata_held", rdata[0], rd);
    endtask

    initial begin
        vec_t        tbl [11];
        logic [31:0] rd, exp_rd, a, wd;
        logic        er, w, oor;
        logic [3:0]  be;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};

        // Reset held with a pending store request.
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h40;
        req_wdata = 32'h0; req_be = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(ready[0]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
            chk("rst_rdata", rdata[0], 32'd0);
            chk("rst_err", 32'(err[0]), 32'd0);
        end
        rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("ready_after_rst", 32'(ready[0]), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b0, rd, er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // No write may happen while reset is held, even with a store presented.
        run_access(1'b1, 32'h40, 32'h5A5A_0F0F, 4'hF, 1'b0, rd, er);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        run_access(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, er);
        chk("rst_no_write", rd, 32'h5A5A_0F0F);

        // Reset in WAIT of a store discards it.
        run_access(1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_resp", 32'(rvalid[0]), 32'd0);
            @(negedge clk);
            if (i == 1) begin rst = 1'b0; req_valid = 1'b0; end
        end
        run_access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er);
        chk("midrst_rdata", rd, 32'h1234_5678);

        // Random accesses against a word-array model.
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            run_access(1'b1, 32'(i * 4), wd, 4'hF, 1'b0, rd, er);
            mdl[i] = wd;
        end
        for (int it = 0; it < 60; it++) begin
            w  = 1'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
            else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            oor    = (a[31:12] != 20'd0);
            exp_rd = (w || oor) ? 32'd0 : mdl[a[11:2]];
            run_access(w, a, wd, be, 1'b1, rd, er);
            chk($sformatf("rnd%0d_rdata", it), rd, exp_rd);
            chk($sformatf("rnd%0d_err", it), 32'(er), 32'(oor));
            if (w && !oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mdl[a[11:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end

        // Continuous requests: all three latency builds run their periodic pattern.
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0; req_be = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            for (int g = 0; g < 3; g++) begin
                int lat;
                bit exp_rdy, exp_rv;
                lat     = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
                exp_rdy = ((n % (lat + 1)) == 0);
                exp_rv  = ((n % (lat + 1)) == lat);
                chk($sformatf("cont_l%0d_ready_n%0d", lat, n), 32'(ready[g]), 32'(exp_rdy));
                chk($sformatf("cont_l%0d_rvalid_n%0d", lat, n), 32'(rvalid[g]), 32'(exp_rv));
                chk($sformatf("cont_l%0d_stall_n%0d", lat, n), 32'(stall[g]), 32'(!exp_rv));
            end
            @(negedge clk);
        end
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
